// File: rtl/id_rr_stage_reg.sv
// Decode -> register-read pipeline register with flush/backpressure/load-use bubble handling,
// immediate formatting on advance, and a saturating count of load-use bubbles.
module id_rr_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              should_stall,
  input  logic              stall_ext,
  input  logic              flush,
  input  logic              valid_decode,
  input  logic [3:0]        op_decode,
  input  logic [2:0]        src1_decode,
  input  logic [2:0]        src2_decode,
  input  logic [2:0]        dest_decode,
  input  logic [8:0]        imm_decode,
  input  logic [1:0]        imm_sel,
  input  logic [DATA_W-1:0] pc_decode,
  output logic              valid_regread,
  output logic [3:0]        op_regread,
  output logic [2:0]        src1_regread,
  output logic [2:0]        src2_regread,
  output logic [2:0]        dest_regread,
  output logic [DATA_W-1:0] imm_regread,
  output logic [DATA_W-1:0] pc_regread,
  output logic              if_id_hold,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_ADVANCE
  } action_t;

  action_t           action;
  logic [DATA_W-1:0] imm_ext;

  always_comb begin
    action = ACT_ADVANCE;
    if (rst)               action = ACT_RESET;
    else if (flush)        action = ACT_FLUSH;
    else if (stall_ext)    action = ACT_HOLD;
    else if (should_stall) action = ACT_BUBBLE;
  end

  always_comb begin
    imm_ext = '0;
    case (imm_sel)
      2'b00:   imm_ext = {{(DATA_W-6){imm_decode[5]}}, imm_decode[5:0]};
      2'b01:   imm_ext = {{(DATA_W-9){imm_decode[8]}}, imm_decode};
      2'b10:   imm_ext = DATA_W'(imm_decode) << 7;  // LHI: field lands in the upper bits
      default: imm_ext = DATA_W'(imm_decode);
    endcase
  end

  assign if_id_hold = (should_stall | stall_ext) & ~flush & ~rst;

  always_ff @(posedge clk) begin
    case (action)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        valid_regread <= 1'b0;
        op_regread    <= 4'b0000;
        src1_regread  <= 3'b000;
        src2_regread  <= 3'b000;
        dest_regread  <= 3'b000;
        imm_regread   <= '0;
        pc_regread    <= '0;
      end
      ACT_ADVANCE: begin
        valid_regread <= valid_decode;
        op_regread    <= op_decode;
        src1_regread  <= src1_decode;
        src2_regread  <= src2_decode;
        dest_regread  <= dest_decode;
        imm_regread   <= imm_ext;
        pc_regread    <= pc_decode;
      end
      default: ;
    endcase
  end

  // Only hazard-inserted bubbles are counted; flush and backpressure are not stalls of ours.
  always_ff @(posedge clk) begin
    if (action == ACT_RESET)
      stall_count <= '0;
    else if (action == ACT_BUBBLE && !(&stall_count))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_rr_stage_reg.sv
// Directed bench for id_rr_stage_reg: a vector table for single-cycle actions plus
// hand sequences for counter saturation and reset during a stall run.
module tb_id_rr_stage_reg;

  logic        clk = 1'b0;
  logic        rst, should_stall, stall_ext, flush, valid_decode;
  logic [3:0]  op_decode;
  logic [2:0]  src1_decode, src2_decode, dest_decode;
  logic [8:0]  imm_decode;
  logic [1:0]  imm_sel;
  logic [15:0] pc_decode;

  logic        s_valid, b_valid, s_hold, b_hold;
  logic [3:0]  s_op, b_op;
  logic [2:0]  s_src1, s_src2, s_dest, b_src1, b_src2, b_dest;
  logic [15:0] s_imm, s_pc, b_imm, b_pc;
  logic [3:0]  s_cnt;
  logic [15:0] b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_rr_stage_reg #(.DATA_W(16), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .should_stall(should_stall), .stall_ext(stall_ext), .flush(flush),
    .valid_decode(valid_decode), .op_decode(op_decode), .src1_decode(src1_decode),
    .src2_decode(src2_decode), .dest_decode(dest_decode), .imm_decode(imm_decode),
    .imm_sel(imm_sel), .pc_decode(pc_decode),
    .valid_regread(s_valid), .op_regread(s_op), .src1_regread(s_src1), .src2_regread(s_src2),
    .dest_regread(s_dest), .imm_regread(s_imm), .pc_regread(s_pc),
    .if_id_hold(s_hold), .stall_count(s_cnt)
  );

  id_rr_stage_reg dut_b (
    .clk(clk), .rst(rst), .should_stall(should_stall), .stall_ext(stall_ext), .flush(flush),
    .valid_decode(valid_decode), .op_decode(op_decode), .src1_decode(src1_decode),
    .src2_decode(src2_decode), .dest_decode(dest_decode), .imm_decode(imm_decode),
    .imm_sel(imm_sel), .pc_decode(pc_decode),
    .valid_regread(b_valid), .op_regread(b_op), .src1_regread(b_src1), .src2_regread(b_src2),
    .dest_regread(b_dest), .imm_regread(b_imm), .pc_regread(b_pc),
    .if_id_hold(b_hold), .stall_count(b_cnt)
  );

  typedef struct {
    logic        rst, ss, se, fl, v;
    logic [3:0]  op;
    logic [2:0]  s1, s2, d;
    logic [8:0]  imm;
    logic [1:0]  sel;
    logic [15:0] pc;
    logic        e_hold, e_v;
    logic [3:0]  e_op;
    logic [2:0]  e_s1, e_s2, e_d;
    logic [15:0] e_imm, e_pc;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, ss, se, fl, v, input logic [3:0] op,
                       input logic [2:0] s1, s2, d, input logic [8:0] imm,
                       input logic [1:0] sel, input logic [15:0] pc);
    rst = r; should_stall = ss; stall_ext = se; flush = fl; valid_decode = v;
    op_decode = op; src1_decode = s1; src2_decode = s2; dest_decode = d;
    imm_decode = imm; imm_sel = sel; pc_decode = pc;
  endtask

  task automatic check_rr(input string tag, input logic v, input logic [3:0] op,
                          input logic [2:0] s1, s2, d, input logic [15:0] imm, pc);
    chk({tag, " valid"}, 32'(s_valid), 32'(v));
    chk({tag, " op"},    32'(s_op),    32'(op));
    chk({tag, " src1"},  32'(s_src1),  32'(s1));
    chk({tag, " src2"},  32'(s_src2),  32'(s2));
    chk({tag, " dest"},  32'(s_dest),  32'(d));
    chk({tag, " imm"},   32'(s_imm),   32'(imm));
    chk({tag, " pc"},    32'(s_pc),    32'(pc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst ss se fl v  op    s1 s2 d  imm     sel   pc     | hold v  op    s1 s2 d  imm       pc       cnt
    vecs[0]  = '{0,0,0,0,1, 4'h1, 2,3,5, 9'h03F, 2'b00, 16'h0010, 0,1, 4'h1, 2,3,5, 16'hFFFF, 16'h0010, 0};
    vecs[1]  = '{0,0,0,0,1, 4'h4, 1,2,3, 9'h0AB, 2'b01, 16'h0014, 0,1, 4'h4, 1,2,3, 16'h00AB, 16'h0014, 0};
    vecs[2]  = '{0,1,0,0,1, 4'h2, 3,4,6, 9'h100, 2'b01, 16'h0018, 1,0, 4'h0, 0,0,0, 16'h0000, 16'h0000, 1};
    vecs[3]  = '{0,0,0,0,1, 4'h2, 3,4,6, 9'h100, 2'b01, 16'h0018, 0,1, 4'h2, 3,4,6, 16'hFF00, 16'h0018, 1};
    vecs[4]  = '{0,0,0,0,0, 4'h7, 7,7,7, 9'h001, 2'b10, 16'h001C, 0,0, 4'h7, 7,7,7, 16'h0080, 16'h001C, 1};
    vecs[5]  = '{0,0,0,0,1, 4'h3, 1,1,2, 9'h1C0, 2'b11, 16'h0020, 0,1, 4'h3, 1,1,2, 16'h01C0, 16'h0020, 1};
    vecs[6]  = '{0,0,1,0,0, 4'hF, 7,6,5, 9'h1FF, 2'b00, 16'hFFFF, 1,1, 4'h3, 1,1,2, 16'h01C0, 16'h0020, 1};
    vecs[7]  = '{0,0,1,0,1, 4'hE, 6,5,4, 9'h155, 2'b01, 16'hAAAA, 1,1, 4'h3, 1,1,2, 16'h01C0, 16'h0020, 1};
    vecs[8]  = '{0,0,1,0,1, 4'hD, 5,4,3, 9'h0AA, 2'b10, 16'h5555, 1,1, 4'h3, 1,1,2, 16'h01C0, 16'h0020, 1};
    vecs[9]  = '{0,1,1,0,1, 4'hC, 4,3,2, 9'h0F0, 2'b11, 16'h1234, 1,1, 4'h3, 1,1,2, 16'h01C0, 16'h0020, 1};
    vecs[10] = '{0,1,1,1,1, 4'hB, 3,2,1, 9'h00F, 2'b00, 16'h4321, 0,0, 4'h0, 0,0,0, 16'h0000, 16'h0000, 1};
    vecs[11] = '{0,0,0,0,1, 4'h5, 4,5,1, 9'h020, 2'b00, 16'h0030, 0,1, 4'h5, 4,5,1, 16'hFFE0, 16'h0030, 1};
    vecs[12] = '{0,0,0,1,1, 4'h6, 2,2,2, 9'h011, 2'b01, 16'h0034, 0,0, 4'h0, 0,0,0, 16'h0000, 16'h0000, 1};
    vecs[13] = '{0,1,0,0,1, 4'h6, 2,2,2, 9'h011, 2'b01, 16'h0038, 1,0, 4'h0, 0,0,0, 16'h0000, 16'h0000, 2};
    vecs[14] = '{1,1,0,0,1, 4'h6, 2,2,2, 9'h011, 2'b01, 16'h003C, 0,0, 4'h0, 0,0,0, 16'h0000, 16'h0000, 0};
    vecs[15] = '{0,0,0,0,1, 4'h1, 1,2,3, 9'h00F, 2'b00, 16'h0040, 0,1, 4'h1, 1,2,3, 16'h000F, 16'h0040, 0};

    // Power-up reset with junk on the decode side.
    drive(1, 0, 0, 0, 1, 4'h9, 1, 1, 1, 9'h1AA, 2'b01, 16'hBEEF);
    tick();
    tick();
    chk("reset hold", 32'(s_hold), 32'd0);
    check_rr("reset", 0, 4'h0, 0, 0, 0, 16'h0000, 16'h0000);
    chk("reset cnt", 32'(s_cnt), 32'd0);
    chk("reset cnt16", 32'(b_cnt), 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].ss, vecs[i].se, vecs[i].fl, vecs[i].v, vecs[i].op,
            vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].imm, vecs[i].sel, vecs[i].pc);
      #1;
      chk($sformatf("v%0d hold", i), 32'(s_hold), 32'(vecs[i].e_hold));
      tick();
      check_rr($sformatf("v%0d", i), vecs[i].e_v, vecs[i].e_op, vecs[i].e_s1, vecs[i].e_s2,
               vecs[i].e_d, vecs[i].e_imm, vecs[i].e_pc);
      chk($sformatf("v%0d cnt", i), 32'(s_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d cnt16", i), 32'(b_cnt), 32'(vecs[i].e_cnt));
    end

    // 17 back-to-back bubbles: 4-bit counter pins at F, 16-bit keeps counting.
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 0, 0, 1, 4'h4, 1, 1, 1, 9'h000, 2'b00, 16'h0050);
      #1;
      chk($sformatf("sat%0d hold", i), 32'(s_hold), 32'd1);
      tick();
      chk($sformatf("sat%0d cnt", i), 32'(s_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      chk($sformatf("sat%0d cnt16", i), 32'(b_cnt), 32'(i + 1));
      chk($sformatf("sat%0d valid", i), 32'(s_valid), 32'd0);
    end
    drive(0, 0, 0, 0, 1, 4'h8, 0, 1, 2, 9'h001, 2'b10, 16'h0060);
    tick();
    check_rr("lhi", 1, 4'h8, 0, 1, 2, 16'h0080, 16'h0060);
    chk("lhi cnt", 32'(s_cnt), 32'd15);
    chk("lhi cnt16", 32'(b_cnt), 32'd17);

    // Reset in the middle of a stall run with count at 5.
    drive(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 9'h000, 2'b00, 16'h0000);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 1, 4'h2, 3, 3, 3, 9'h003, 2'b00, 16'h0070);
      tick();
    end
    chk("pre-rst cnt", 32'(s_cnt), 32'd5);
    chk("pre-rst cnt16", 32'(b_cnt), 32'd5);
    drive(0, 0, 0, 0, 1, 4'h2, 3, 3, 3, 9'h003, 2'b00, 16'h0070);
    tick();
    drive(1, 1, 0, 0, 1, 4'h2, 3, 3, 3, 9'h003, 2'b00, 16'h0074);
    #1;
    chk("midrst hold", 32'(s_hold), 32'd0);
    tick();
    check_rr("midrst", 0, 4'h0, 0, 0, 0, 16'h0000, 16'h0000);
    chk("midrst cnt", 32'(s_cnt), 32'd0);
    chk("midrst cnt16", 32'(b_cnt), 32'd0);
    drive(0, 0, 0, 0, 1, 4'h2, 3, 3, 3, 9'h003, 2'b00, 16'h0078);
    tick();
    check_rr("post-rst", 1, 4'h2, 3, 3, 3, 16'h0003, 16'h0078);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_rr_stage_reg.md
ID_RR_STAGE_REG -- requirements
Module: id_rr_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of PC and immediate datapath.
REQ-002 SHALL have parameter CNT_W, default 16, width of the load-use stall counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 should_stall  input  1  load-use stall request from the hazard detection unit.
REQ-006 stall_ext  input  1  downstream backpressure; freeze this register.
REQ-007 flush  input  1  branch/jump redirect; kill the instruction in decode.
REQ-008 valid_decode  input  1  decode stage holds a real instruction.
REQ-009 op_decode  input  4  opcode from decode.
REQ-010 src1_decode, src2_decode, dest_decode  input  3 each  register indices.
REQ-011 imm_decode  input  9  raw immediate field.
REQ-012 imm_sel  input  2  immediate format select.
REQ-013 pc_decode  input  DATA_W  PC of the decode instruction.
REQ-014 valid_regread, op_regread(4), src1_regread(3), src2_regread(3), dest_regread(3), imm_regread(DATA_W), pc_regread(DATA_W)  output  registered RR-stage fields.
REQ-015 if_id_hold  output  1  combinational; tells fetch and IF/ID register to hold.
REQ-016 stall_count  output  CNT_W  registered count of bubble cycles inserted.

Function
REQ-017 Each cycle the register SHALL take exactly one action, priority: rst > flush > stall_ext > should_stall > advance.
REQ-018 Advance: all RR fields SHALL load the decode fields; valid_regread SHALL equal valid_decode.
REQ-019 stall_ext (no flush): all RR fields SHALL hold their current values.
REQ-020 should_stall (no flush, no stall_ext): RR SHALL load a bubble: valid_regread=0, op_regread=4'b0000, src1/src2/dest_regread=3'b000, imm_regread=0, pc_regread=0.
REQ-021 flush (no rst): RR SHALL load a bubble; flush SHALL override both stall sources in the same cycle.
REQ-022 if_id_hold SHALL equal (should_stall | stall_ext) & ~flush & ~rst.
REQ-023 Bubble opcode 4'b0000 is not the load opcode 4'b0100; should_stall from the hazard unit SHALL deassert the cycle after a bubble enters, so a load-use stall lasts exactly one cycle.
REQ-024 Immediate, computed on advance: imm_sel 00 = sign-extend imm_decode[5:0]; 01 = sign-extend imm_decode[8:0]; 10 = {imm_decode[8:0], 7'b0} (LHI form); 11 = zero-extend imm_decode[8:0]; all to DATA_W bits.
REQ-025 stall_count SHALL increment by 1 on each cycle where a should_stall bubble is inserted (REQ-020 case only), saturating at all-ones; flush and stall_ext cycles SHALL NOT count.
REQ-026 Latency decode->regread SHALL be exactly one clk cycle when advancing.
REQ-027 Fields SHALL be loaded regardless of valid_decode; valid_regread alone qualifies them.

Reset
REQ-028 On rst=1 at a clk edge: valid_regread=0, all other RR fields=0, stall_count=0.
REQ-029 rst mid-stall or mid-flush SHALL take priority; first post-reset cycle SHALL behave as advance if no other input is active.
REQ-030 stall_count SHALL be cleared only by rst.

Verification
REQ-031 Advance: valid_decode=1, op=4'b0001, src1=2, src2=3, dest=5, imm_decode=9'h03F, imm_sel=00, pc=16'h0010 -> next cycle valid_regread=1, dest_regread=5, imm_regread=16'hFFFF, pc_regread=16'h0010.
REQ-032 Load-use: RR holds op 4'b0100 dest=3; decode src1=3; should_stall=1 for one cycle -> if_id_hold=1 that cycle, RR becomes bubble (valid=0, op=0), stall_count 0->1; next cycle decode instruction advances unchanged.
REQ-033 Flush over stall: should_stall=1, stall_ext=1, flush=1 same cycle -> if_id_hold=0, RR bubble, stall_count unchanged.
REQ-034 Backpressure: stall_ext=1 for 3 cycles with RR holding pc=16'h0020 -> pc_regread stays 16'h0020, valid stays 1, if_id_hold=1 all 3 cycles, stall_count unchanged.
REQ-035 Saturation with CNT_W=4: 17 consecutive should_stall bubble cycles -> stall_count reaches 4'hF and stays; imm_sel=10, imm_decode=9'h001 on advance -> imm_regread=16'h0080.
REQ-036 Reset mid-operation: rst=1 while should_stall=1 and stall_count=5 -> next cycle all outputs 0, if_id_hold=0 during rst.
